regfile_commit_ctrl: RTL and testbench
======================================

# regfile_commit_ctrl

Register-status and write-port controller for the 32-entry register file. It tracks which architectural registers have an in-flight producer, and the ROB tag of that producer. It answers busy/tag lookups for the two decode source operands and drives the register file's single write port from ROB commit. It enforces the x0 rules and clears all speculative state on a pipeline flush.

## Interface
Parameters:
- A_WIDTH, 4: register address MSB index (32 registers).
- D_WIDTH, 31: data MSB index (32-bit values).
- TAG_WIDTH, 2: ROB tag MSB index (8-entry ROB).

Ports:
- clk  in  1  core clock; all state updates on posedge.
- resetN  in  1  asynchronous, active-low reset.
- flush  in  1  mispredict/exception flush; clears all busy state.
- dispValid  in  1  decode dispatches an instruction that writes rd.
- dispRd  in  A_WIDTH+1  destination register of the dispatched instruction.
- dispTag  in  TAG_WIDTH+1  ROB tag allocated to the dispatched instruction.
- src1, src2  in  A_WIDTH+1  each: source registers being decoded.
- commitValid  in  1  ROB commits an instruction with a destination.
- commitRd  in  A_WIDTH+1  destination register of the committing instruction.
- commitTag  in  TAG_WIDTH+1  ROB tag of the committing instruction.
- commitData  in  D_WIDTH+1  result value of the committing instruction.
- src1Busy, src2Busy  out  1  each: the source awaits an in-flight producer.
- src1Tag, src2Tag  out  TAG_WIDTH+1  each: tag of that producer; 0 when not busy.
- regWrite  out  1  register file write enable.
- wraddress  out  A_WIDTH+1  register file write address.
- wdata  out  D_WIDTH+1  register file write data.
- busyCount  out  A_WIDTH+2  number of registers currently marked busy.

## Operation
State:
- busy[31:0] and tag[31:0][TAG_WIDTH:0], both registered.
- busyCount, registered; always equals popcount(busy).

Reset (resetN=0, asynchronous):
- busy, tag and busyCount all cleared to 0.
- Lookup outputs therefore read 0.
- regWrite follows its equation, so it is 0 whenever commitValid=0.

Dispatch:
- If dispValid, dispRd!=0 and flush=0: busy[dispRd]←1 and tag[dispRd]←dispTag at the next edge.
- Dispatch to x0 is ignored; busy[0] is never set.

Commit:
- If commitValid and busy[commitRd] and tag[commitRd]==commitTag: busy[commitRd]←1'b0.
- If the tag does not match, a younger producer owns the register and busy is unchanged.

Same register, same cycle:
- When dispatch and commit target the same register, dispatch wins.
- The entry ends busy with dispTag; busyCount is unchanged.

Flush:
- The entire busy vector clears at the next edge; busyCount←0.
- A same-cycle dispatch is discarded.
- A same-cycle commit still writes the register file, because the committing instruction is older than the flush point.

Write port (combinational from commit inputs):
- regWrite = commitValid.
- wraddress = commitRd.
- wdata = (commitRd==0) ? 0 : commitData.
- x0 therefore always holds zero.

Lookup (combinational):
- srcNBusy = busy[srcN] && !(commitValid && commitRd==srcN && commitTag==tag[srcN]).
- srcNTag = srcNBusy ? tag[srcN] : 0.
- src==0 always reads not busy.
- A same-cycle dispatch does not affect lookups: an instruction's sources see state from before its own rd is marked.

## Timing
- Lookup and write-port outputs: zero-cycle latency (combinational).
- Busy/tag table and busyCount: update one edge after dispatch, commit or flush.
- Commit bypass: a source whose producer commits in cycle N reads not-busy in cycle N. The register file's new-data behavior supplies the value in that same cycle.
- Reset asserted mid-operation clears all state immediately, regardless of clk.
- Operation resumes on the first posedge after resetN rises.

## Structure
- Shared package core_pkg holds the width constants and typedefs:
  - reg_addr_t (A_WIDTH+1 bits)
  - rob_tag_t (TAG_WIDTH+1 bits)
  - word_t (D_WIDTH+1 bits)
- The same package is used by the ROB and decode.
- One natural sub-module: busy_tag_table. It holds the 32-entry busy/tag storage with one set port, one tag-matched clear port and a flush port.
- The top level adds the write-port logic, lookup bypass and busyCount.

## Test plan
- Reset then lookup src1=5, src2=0 -> both busy=0, tag=0, busyCount=0, regWrite=0.
- Dispatch rd=5, tag=3; next cycle src1=5 -> src1Busy=1, src1Tag=3, busyCount=1.
- Dispatch rd=0, tag=2 -> busy[0] stays 0. Commit rd=0, data=0xDEADBEEF -> regWrite=1, wraddress=0, wdata=0.
- x5 busy with tag 3; same cycle dispatch rd=5 tag=6 and commit rd=5 tag=3 -> next cycle src1=5 shows busy=1, tag=6, busyCount unchanged.
- x7 busy with tag 1; commit rd=7 tag=1, data=0x1234, while src2=7 -> src2Busy=0 in the same cycle, wdata=0x1234, busy[7]=0 next cycle. Commit rd=7 with tag 4 instead -> x7 stays busy.
- Three registers busy; assert flush with dispValid rd=9 and commitValid rd=3 -> regWrite=1 that cycle; next cycle all busy=0, busyCount=0, x9 not busy.
- Assert resetN=0 mid-stream between clock edges -> outputs clear without waiting for clk.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core widths and typedefs, used by the ROB, decode and the
// register-status controller.
package core_pkg;

  localparam int CORE_A_WIDTH   = 4;
  localparam int CORE_D_WIDTH   = 31;
  localparam int CORE_TAG_WIDTH = 2;
  localparam int CORE_NUM_REGS  = 2 ** (CORE_A_WIDTH + 1);

  typedef logic [CORE_A_WIDTH:0]   reg_addr_t;
  typedef logic [CORE_TAG_WIDTH:0] rob_tag_t;
  typedef logic [CORE_D_WIDTH:0]   word_t;

endpackage

// File: rtl/busy_tag_table.sv
// Busy/tag storage for the architectural registers: one set port (dispatch),
// one tag-matched clear port (commit) and a flush that drops all busy bits.
module busy_tag_table
  import core_pkg::*;
#(
  parameter int A_WIDTH   = CORE_A_WIDTH,
  parameter int TAG_WIDTH = CORE_TAG_WIDTH,
  localparam int NREG     = 2 ** (A_WIDTH + 1)
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic                          flush,
  input  logic                          set_en,
  input  logic [A_WIDTH:0]              set_addr,
  input  logic [TAG_WIDTH:0]            set_tag,
  input  logic                          clr_en,
  input  logic [A_WIDTH:0]              clr_addr,
  input  logic [TAG_WIDTH:0]            clr_tag,
  output logic [NREG-1:0]               busy,
  output logic [NREG-1:0][TAG_WIDTH:0]  tags,
  output logic [NREG-1:0]               busy_nxt
);

  logic [NREG-1:0][TAG_WIDTH:0] tags_nxt;
  logic                         set_hit;
  logic                         clr_hit;

  assign set_hit = set_en && (set_addr != '0) && !flush;
  assign clr_hit = clr_en && busy[clr_addr] && (tags[clr_addr] == clr_tag);

  // Clear is applied before set so a same-register dispatch wins.
  always_comb begin
    busy_nxt = busy;
    tags_nxt = tags;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (clr_hit) busy_nxt[clr_addr] = 1'b0;
      if (set_hit) begin
        busy_nxt[set_addr] = 1'b1;
        tags_nxt[set_addr] = set_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      busy <= '0;
      tags <= '0;
    end else begin
      busy <= busy_nxt;
      tags <= tags_nxt;
    end
  end

endmodule

// File: rtl/regfile_commit_ctrl.sv
// Register-status and write-port controller: busy/tag lookups with commit
// bypass for two decode sources, register file write port, busy count.
module regfile_commit_ctrl
  import core_pkg::*;
#(
  parameter int A_WIDTH   = CORE_A_WIDTH,
  parameter int D_WIDTH   = CORE_D_WIDTH,
  parameter int TAG_WIDTH = CORE_TAG_WIDTH
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 flush,
  input  logic                 dispValid,
  input  logic [A_WIDTH:0]     dispRd,
  input  logic [TAG_WIDTH:0]   dispTag,
  input  logic [A_WIDTH:0]     src1,
  input  logic [A_WIDTH:0]     src2,
  input  logic                 commitValid,
  input  logic [A_WIDTH:0]     commitRd,
  input  logic [TAG_WIDTH:0]   commitTag,
  input  logic [D_WIDTH:0]     commitData,
  output logic                 src1Busy,
  output logic                 src2Busy,
  output logic [TAG_WIDTH:0]   src1Tag,
  output logic [TAG_WIDTH:0]   src2Tag,
  output logic                 regWrite,
  output logic [A_WIDTH:0]     wraddress,
  output logic [D_WIDTH:0]     wdata,
  output logic [A_WIDTH+1:0]   busyCount
);

  localparam int NREG = 2 ** (A_WIDTH + 1);

  logic [NREG-1:0]              busy;
  logic [NREG-1:0]              busy_nxt;
  logic [NREG-1:0][TAG_WIDTH:0] tags;
  logic                         src1_commit_hit;
  logic                         src2_commit_hit;

  function automatic logic [A_WIDTH+1:0] popcount(input logic [NREG-1:0] v);
    logic [A_WIDTH+1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt = cnt + {{(A_WIDTH+1){1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  busy_tag_table #(
    .A_WIDTH   (A_WIDTH),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_table (
    .clk      (clk),
    .resetN   (resetN),
    .flush    (flush),
    .set_en   (dispValid),
    .set_addr (dispRd),
    .set_tag  (dispTag),
    .clr_en   (commitValid),
    .clr_addr (commitRd),
    .clr_tag  (commitTag),
    .busy     (busy),
    .tags     (tags),
    .busy_nxt (busy_nxt)
  );

  // Write port: a commit writes even under flush; x0 is forced to zero.
  assign regWrite  = commitValid;
  assign wraddress = commitRd;
  assign wdata     = (commitRd == '0) ? '0 : commitData;

  // A source whose producer commits this cycle is already resolved.
  assign src1_commit_hit = commitValid && (commitRd == src1) && (commitTag == tags[src1]);
  assign src2_commit_hit = commitValid && (commitRd == src2) && (commitTag == tags[src2]);

  assign src1Busy = busy[src1] && !src1_commit_hit;
  assign src2Busy = busy[src2] && !src2_commit_hit;
  assign src1Tag  = src1Busy ? tags[src1] : '0;
  assign src2Tag  = src2Busy ? tags[src2] : '0;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      busyCount <= '0;
    end else begin
      busyCount <= popcount(busy_nxt);
    end
  end

endmodule

// File: tb/tb_regfile_commit_ctrl.sv
// Bench for regfile_commit_ctrl: directed scenarios then random traffic
// against an array-based register-status model.
module tb_regfile_commit_ctrl;
  import core_pkg::*;

  logic      clk = 1'b0;
  logic      resetN;
  logic      flush;
  logic      dispValid;
  reg_addr_t dispRd;
  rob_tag_t  dispTag;
  reg_addr_t src1, src2;
  logic      commitValid;
  reg_addr_t commitRd;
  rob_tag_t  commitTag;
  word_t     commitData;
  logic      src1Busy, src2Busy;
  rob_tag_t  src1Tag, src2Tag;
  logic      regWrite;
  reg_addr_t wraddress;
  word_t     wdata;
  logic [5:0] busyCount;

  int errors = 0;
  int checks = 0;

  bit m_busy [32];
  int m_tag  [32];

  always #5 clk = ~clk;

  regfile_commit_ctrl dut (
    .clk(clk), .resetN(resetN), .flush(flush),
    .dispValid(dispValid), .dispRd(dispRd), .dispTag(dispTag),
    .src1(src1), .src2(src2),
    .commitValid(commitValid), .commitRd(commitRd), .commitTag(commitTag),
    .commitData(commitData),
    .src1Busy(src1Busy), .src2Busy(src2Busy), .src1Tag(src1Tag), .src2Tag(src2Tag),
    .regWrite(regWrite), .wraddress(wraddress), .wdata(wdata), .busyCount(busyCount)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic drive(input int dv, input int drd, input int dtag,
                       input int cv, input int crd, input int ctag, input int cdata,
                       input int fl, input int s1, input int s2);
    dispValid   = 1'(dv);
    dispRd      = 5'(drd);
    dispTag     = 3'(dtag);
    commitValid = 1'(cv);
    commitRd    = 5'(crd);
    commitTag   = 3'(ctag);
    commitData  = 32'(cdata);
    flush       = 1'(fl);
    src1        = 5'(s1);
    src2        = 5'(s2);
    #1;
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  // Source is pending unless its current producer is committing right now.
  function automatic bit exp_busy(input int s);
    if (commitValid && int'(commitRd) == s && int'(commitTag) == m_tag[s]) return 1'b0;
    return m_busy[s];
  endfunction

  task automatic check_all(input string tag);
    int s1 = int'(src1);
    int s2 = int'(src2);
    bit b1 = exp_busy(s1);
    bit b2 = exp_busy(s2);
    chk({tag, ".src1Busy"}, 32'(src1Busy), 32'(b1));
    chk({tag, ".src1Tag"},  32'(src1Tag),  b1 ? 32'(m_tag[s1]) : 32'd0);
    chk({tag, ".src2Busy"}, 32'(src2Busy), 32'(b2));
    chk({tag, ".src2Tag"},  32'(src2Tag),  b2 ? 32'(m_tag[s2]) : 32'd0);
    chk({tag, ".regWrite"}, 32'(regWrite), 32'(commitValid));
    chk({tag, ".wraddress"}, 32'(wraddress), 32'(commitRd));
    chk({tag, ".wdata"}, wdata, (commitRd == 0) ? 32'd0 : commitData);
    chk({tag, ".busyCount"}, 32'(busyCount), 32'(model_count()));
  endtask

  task automatic tick();
    @(posedge clk);
    if (flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (commitValid && m_busy[commitRd] && m_tag[commitRd] == int'(commitTag))
        m_busy[commitRd] = 1'b0;
      if (dispValid && dispRd != 0) begin
        m_busy[dispRd] = 1'b1;
        m_tag[dispRd]  = int'(dispTag);
      end
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_busy[i] = 1'b0;
      m_tag[i]  = 0;
    end
    resetN = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    #10;
    chk("rst.src1Busy", 32'(src1Busy), 32'd0);
    chk("rst.src1Tag", 32'(src1Tag), 32'd0);
    chk("rst.src2Busy", 32'(src2Busy), 32'd0);
    chk("rst.busyCount", 32'(busyCount), 32'd0);
    chk("rst.regWrite", 32'(regWrite), 32'd0);
    @(posedge clk);
    #1 resetN = 1'b1;

    // Dispatch x5 tag 3
    drive(1, 5, 3, 0, 0, 0, 0, 0, 5, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    check_all("disp5");
    chk("disp5.busy", 32'(src1Busy), 32'd1);
    chk("disp5.tag", 32'(src1Tag), 32'd3);
    chk("disp5.count", 32'(busyCount), 32'd1);

    // x0 rules
    drive(1, 0, 2, 0, 0, 0, 0, 0, 0, 5);
    tick();
    drive(0, 0, 0, 1, 0, 0, 32'hDEADBEEF, 0, 0, 5);
    check_all("x0");
    chk("x0.src1Busy", 32'(src1Busy), 32'd0);
    chk("x0.regWrite", 32'(regWrite), 32'd1);
    chk("x0.wraddress", 32'(wraddress), 32'd0);
    chk("x0.wdata", wdata, 32'd0);
    chk("x0.count", 32'(busyCount), 32'd1);
    tick();

    // Same-register dispatch and commit: dispatch wins
    drive(1, 5, 6, 1, 5, 3, 32'h55, 0, 5, 0);
    check_all("same.cyc");
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    check_all("same");
    chk("same.busy", 32'(src1Busy), 32'd1);
    chk("same.tag", 32'(src1Tag), 32'd6);
    chk("same.count", 32'(busyCount), 32'd1);

    // Commit bypass on x7, then stale-tag commit
    drive(1, 7, 1, 0, 0, 0, 0, 0, 5, 7);
    tick();
    drive(0, 0, 0, 1, 7, 1, 32'h1234, 0, 5, 7);
    check_all("byp");
    chk("byp.src2Busy", 32'(src2Busy), 32'd0);
    chk("byp.wdata", wdata, 32'h1234);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 7);
    chk("byp.after", 32'(src2Busy), 32'd0);
    chk("byp.count", 32'(busyCount), 32'd1);
    drive(1, 7, 1, 0, 0, 0, 0, 0, 5, 7);
    tick();
    drive(0, 0, 0, 1, 7, 4, 32'h99, 0, 5, 7);
    chk("stale.cyc", 32'(src2Busy), 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 7);
    check_all("stale");
    chk("stale.busy", 32'(src2Busy), 32'd1);
    chk("stale.tag", 32'(src2Tag), 32'd1);

    // Flush with same-cycle dispatch and commit
    drive(1, 3, 2, 0, 0, 0, 0, 0, 5, 7);
    tick();
    chk("pre.count", 32'(busyCount), 32'd3);
    drive(1, 9, 5, 1, 3, 2, 32'hAA, 1, 9, 3);
    check_all("flush.cyc");
    chk("flush.regWrite", 32'(regWrite), 32'd1);
    chk("flush.wdata", wdata, 32'hAA);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 5);
    check_all("flush");
    chk("flush.count", 32'(busyCount), 32'd0);
    chk("flush.x9", 32'(src1Busy), 32'd0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      int crd = int'($urandom_range(0, 9));
      int ctag = ($urandom_range(0, 1) == 0) ? m_tag[crd] : int'($urandom_range(0, 7));
      drive(int'($urandom_range(0, 1)), int'($urandom_range(0, 9)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 1)), crd, ctag, int'($urandom),
            ($urandom_range(0, 15) == 0) ? 1 : 0,
            int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
      check_all("rnd");
      tick();
    end

    // Asynchronous reset between edges
    drive(1, 10, 5, 0, 0, 0, 0, 0, 10, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 10, 0);
    chk("arst.pre", 32'(src1Busy), 32'd1);
    #1 resetN = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    for (int i = 0; i < 32; i++) m_tag[i] = 0;
    chk("arst.src1Busy", 32'(src1Busy), 32'd0);
    chk("arst.src1Tag", 32'(src1Tag), 32'd0);
    chk("arst.count", 32'(busyCount), 32'd0);
    @(posedge clk);
    #1 resetN = 1'b1;
    drive(1, 4, 7, 0, 0, 0, 0, 0, 4, 10);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 4, 10);
    check_all("resume");
    chk("resume.tag", 32'(src1Tag), 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
